// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and width for the Y86-64 execute ALU
package alu_pkg;
  localparam int WIDTH = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
endpackage

// File: rtl/alu_add_sub_64.sv
// rtl/alu_add_sub_64.sv - structural ripple adder/subtractor built from full_adder cells
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_sub_64 import alu_pkg::*; (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   carry;

  // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in.
  assign b_x      = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_x[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = carry[WIDTH] ^ carry[WIDTH-1];
endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 64-bit ADD/SUB/AND/XOR ALU with registered result and overflow flag
module alu import alu_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [1:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag
);
  logic [WIDTH-1:0] arith_sum;
  logic             arith_ovf;
  logic [WIDTH-1:0] result_d, result_q;
  logic             ovf_d, ovf_q;

  add_sub_64 u_add_sub (
    .a   (num1),
    .b   (num2),
    .sub (operation == ALU_SUB),
    .sum (arith_sum),
    .ovf (arith_ovf)
  );

  always_comb begin
    result_d = arith_sum;
    ovf_d    = 1'b0;
    case (operation)
      ALU_ADD: begin result_d = arith_sum;   ovf_d = arith_ovf; end
      ALU_SUB: begin result_d = arith_sum;   ovf_d = arith_ovf; end
      ALU_AND: begin result_d = num1 & num2; ovf_d = 1'b0;      end
      ALU_XOR: begin result_d = num1 ^ num2; ovf_d = 1'b0;      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result        = result_q;
  assign overflow_flag = ovf_q;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed vector table, reset sequence and random model check for alu
module tb_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] num1 = '0;
  logic [63:0] num2 = '0;
  logic [1:0]  operation = 2'b00;
  logic [63:0] result;
  logic        overflow_flag;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk           (clk),
    .rst           (rst),
    .num1          (num1),
    .num2          (num2),
    .operation     (operation),
    .result        (result),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_r;
    logic        exp_o;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] r, input logic o);
    checks++;
    if (result !== r || overflow_flag !== o) begin
      errors++;
      $display("FAIL %s: got result=%h ovf=%b, expected result=%h ovf=%b",
               name, result, overflow_flag, r, o);
    end
  endtask

  task automatic apply(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    operation = op;
    num1      = a;
    num2      = b;
    @(posedge clk);
    #1;
  endtask

  // Independent reference: 65-bit signed arithmetic, overflow when the result leaves 64-bit range.
  function automatic void model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic o);
    logic signed [64:0] w;
    w = '0;
    o = 1'b0;
    case (op)
      2'b00: begin w = $signed({a[63], a}) + $signed({b[63], b}); r = w[63:0]; o = w[64] ^ w[63]; end
      2'b01: begin w = $signed({a[63], a}) - $signed({b[63], b}); r = w[63:0]; o = w[64] ^ w[63]; end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
  endfunction

  initial begin
    logic [63:0] ra, rb, er;
    logic        eo;

    vecs[0] = '{"add_max_max",   2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[1] = '{"add_pos_neg",   2'b00, 64'h7FFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0003, 64'h0,                   1'b0};
    vecs[2] = '{"add_neg_neg",   2'b00, 64'h8000_0000_0000_0003, 64'h8000_0000_0000_0003, 64'h6,                   1'b1};
    vecs[3] = '{"add_m5_107",    2'b00, 64'hFFFF_FFFF_FFFF_FFFB, 64'd107,                 64'd102,                 1'b0};
    vecs[4] = '{"sub_min_1",     2'b01, 64'h8000_0000_0000_0000, 64'd1,                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5] = '{"sub_10_3",      2'b01, 64'd10,                  64'd3,                   64'd7,                   1'b0};
    vecs[6] = '{"sub_0_min",     2'b01, 64'h0,                   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
    vecs[7] = '{"and_pattern",   2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0};

    #1;
    check("reset_state", 64'h0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 64'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].exp_r, vecs[i].exp_o);
    end

    apply(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    check("xor_self", 64'h0, 1'b0);
    apply(2'b11, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
    check("xor_pattern", 64'hF0F0_0F0F_F0F0_0F0F, 1'b0);

    // Reset between edges clears at once; the edge after release shows the new operation.
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("pre_reset_add", 64'h8000_0000_0000_0000, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 64'h0, 1'b0);
    num1 = 64'd40;
    num2 = 64'd2;
    operation = 2'b00;
    @(posedge clk);
    #1;
    check("reset_discard", 64'h0, 1'b0);
    rst = 1'b0;
    apply(2'b01, 64'd40, 64'd2);
    check("post_reset_sub", 64'd38, 1'b0);

    // Back-to-back opcode changes every cycle against the model.
    for (int it = 0; it < 20; it++) begin
      for (int op = 0; op < 4; op++) begin
        if (it % 2 == 0) begin
          ra = {{32{1'b0}}, $urandom()};
          rb = {{32{1'b0}}, $urandom()};
          if (it % 4 == 0) ra = {{32{ra[31]}}, ra[31:0]};
        end else begin
          ra = {$urandom(), $urandom()};
          rb = {$urandom(), $urandom()};
        end
        model(2'(op), ra, rb, er, eo);
        apply(2'(op), ra, rb);
        check($sformatf("rand_it%0d_op%0d", it, op), er, eo);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
